// File: rtl/matrix_mult_seq_mac_if.sv
// Job/result handshake bundle for the sequential matrix multiplier.
// The host drives the master side; the multiplier sits on the slave side.
interface matrix_mult_seq_mac_if #(
    parameter int MAX_SIZE   = 10,
    parameter int DATA_WIDTH = 32
);
    localparam int FLAT_W = MAX_SIZE * MAX_SIZE * DATA_WIDTH;

    logic [31:0]       matrix_size;
    logic              signed_mode;
    logic [FLAT_W-1:0] A;
    logic [FLAT_W-1:0] B;
    logic              in_valid;
    logic              in_ready;
    logic [FLAT_W-1:0] C;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              overflow;

    modport master (
        output matrix_size, signed_mode, A, B, in_valid, out_ready,
        input  in_ready, C, out_valid, busy, overflow
    );

    modport slave (
        input  matrix_size, signed_mode, A, B, in_valid, out_ready,
        output in_ready, C, out_valid, busy, overflow
    );
endinterface

// File: rtl/matrix_mult_seq_mac.sv
// Sequential C = A x B using one row of MAX_SIZE MAC units; one row of C
// is finished every n cycles, with signed/unsigned mode and saturation.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for a job; previous C/overflow still readable
// COMPUTE | accumulating A[i][k]*B[k][j] over k for the current row i
// FINAL   | one settling cycle after the last row is written
// DONE    | result presented until the consumer takes it
module matrix_mult_seq_mac #(
    parameter int MAX_SIZE   = 10,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
    parameter bit SATURATE   = 1'b1
) (
    input logic clk,
    input logic rst,
    matrix_mult_seq_mac_if.slave bus
);
    localparam int IDX_W = $clog2(MAX_SIZE + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FINAL   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]      n_eff;
    logic [IDX_W-1:0]      n_req;
    logic [IDX_W-1:0]      row_idx;
    logic [IDX_W-1:0]      k_idx;
    logic                  sm;
    logic                  overflow_q;
    logic                  accept;
    logic                  row_end;
    logic                  last_step;

    logic [DATA_WIDTH-1:0] a_mat [MAX_SIZE][MAX_SIZE];
    logic [DATA_WIDTH-1:0] b_mat [MAX_SIZE][MAX_SIZE];
    logic [DATA_WIDTH-1:0] c_mat [MAX_SIZE][MAX_SIZE];
    logic [ACC_WIDTH-1:0]  acc   [MAX_SIZE];
    logic [ACC_WIDTH-1:0]  sum   [MAX_SIZE];
    logic [DATA_WIDTH-1:0] res_val [MAX_SIZE];
    logic [MAX_SIZE-1:0]   res_ovf;

    // Both operands are extended to the accumulator width first, so the low
    // ACC_WIDTH bits of the product are the exact signed/unsigned product.
    function automatic logic [ACC_WIDTH-1:0] ext_product(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic                  sgn
    );
        logic [ACC_WIDTH-1:0] ax;
        logic [ACC_WIDTH-1:0] bx;
        ax = {{(ACC_WIDTH-DATA_WIDTH){sgn & a[DATA_WIDTH-1]}}, a};
        bx = {{(ACC_WIDTH-DATA_WIDTH){sgn & b[DATA_WIDTH-1]}}, b};
        return ax * bx;
    endfunction

    // Returns {overflow, value} for one finished sum.
    function automatic logic [DATA_WIDTH:0] convert(
        input logic [ACC_WIDTH-1:0] v,
        input logic                 sgn
    );
        logic                  ovf;
        logic [DATA_WIDTH-1:0] bound;
        logic [DATA_WIDTH-1:0] val;
        if (sgn) begin
            ovf   = (v[ACC_WIDTH-1:DATA_WIDTH-1] != {(ACC_WIDTH-DATA_WIDTH+1){v[ACC_WIDTH-1]}});
            bound = v[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            ovf   = |v[ACC_WIDTH-1:DATA_WIDTH];
            bound = {DATA_WIDTH{1'b1}};
        end
        val = (ovf && SATURATE) ? bound : v[DATA_WIDTH-1:0];
        return {ovf, val};
    endfunction

    assign accept    = (state == ST_IDLE) && bus.in_valid;
    assign n_req     = (bus.matrix_size > 32'(MAX_SIZE)) ? IDX_W'(MAX_SIZE)
                                                         : IDX_W'(bus.matrix_size);
    assign row_end   = (k_idx == n_eff - 1'b1);
    assign last_step = row_end && (row_idx == n_eff - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_next = (n_req == '0) ? ST_FINAL : ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (last_step) begin
                    state_next = ST_FINAL;
                end
            end
            ST_FINAL: state_next = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Units at or beyond n_eff see a zero sum, so they write 0 and never flag.
    always_comb begin
        for (int j = 0; j < MAX_SIZE; j++) begin
            sum[j] = '0;
            if (j < int'(n_eff)) begin
                sum[j] = acc[j] + ext_product(a_mat[row_idx][k_idx], b_mat[k_idx][j], sm);
            end
            {res_ovf[j], res_val[j]} = convert(sum[j], sm);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < MAX_SIZE; r++) begin
                for (int c = 0; c < MAX_SIZE; c++) begin
                    a_mat[r][c] <= bus.A[(r*MAX_SIZE+c)*DATA_WIDTH +: DATA_WIDTH];
                    b_mat[r][c] <= bus.B[(r*MAX_SIZE+c)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            n_eff      <= rst ? '0 : n_req;
            sm         <= rst ? 1'b0 : bus.signed_mode;
            row_idx    <= '0;
            k_idx      <= '0;
            overflow_q <= 1'b0;
            for (int j = 0; j < MAX_SIZE; j++) begin
                acc[j] <= '0;
            end
            for (int r = 0; r < MAX_SIZE; r++) begin
                for (int c = 0; c < MAX_SIZE; c++) begin
                    c_mat[r][c] <= '0;
                end
            end
        end else if (state == ST_COMPUTE) begin
            if (row_end) begin
                for (int j = 0; j < MAX_SIZE; j++) begin
                    acc[j]            <= '0;
                    c_mat[row_idx][j] <= res_val[j];
                end
                overflow_q <= overflow_q | (|res_ovf);
                k_idx      <= '0;
                row_idx    <= last_step ? '0 : row_idx + 1'b1;
            end else begin
                for (int j = 0; j < MAX_SIZE; j++) begin
                    acc[j] <= sum[j];
                end
                k_idx <= k_idx + 1'b1;
            end
        end
    end

    always_comb begin
        bus.C = '0;
        for (int r = 0; r < MAX_SIZE; r++) begin
            for (int c = 0; c < MAX_SIZE; c++) begin
                bus.C[(r*MAX_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] = c_mat[r][c];
            end
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_matrix_mult_seq_mac.sv
// Bench for matrix_mult_seq_mac: a saturating and a truncating instance run
// in lockstep on the same stimulus and are scored against a 128-bit model.
module tb_matrix_mult_seq_mac;
    localparam int MS = 10;
    localparam int DW = 32;
    localparam int W  = MS*MS*DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] c_sat;
        bit           ovf_sat;
        logic [W-1:0] c_trn;
        bit           ovf_trn;
        int           lat;
    } exp_t;

    exp_t sb[$];

    matrix_mult_seq_mac_if #(.MAX_SIZE(MS), .DATA_WIDTH(DW)) bus_s ();
    matrix_mult_seq_mac_if #(.MAX_SIZE(MS), .DATA_WIDTH(DW)) bus_t ();

    matrix_mult_seq_mac #(.MAX_SIZE(MS), .DATA_WIDTH(DW), .ACC_WIDTH(2*DW+4), .SATURATE(1'b1))
        dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    matrix_mult_seq_mac #(.MAX_SIZE(MS), .DATA_WIDTH(DW), .ACC_WIDTH(2*DW+4), .SATURATE(1'b0))
        dut_t (.clk(clk), .rst(rst), .bus(bus_t));

    function automatic logic [W-1:0] put(input logic [W-1:0] m, input int r, input int c,
                                         input logic [31:0] v);
        m[(r*MS+c)*DW +: DW] = v;
        return m;
    endfunction

    function automatic logic [31:0] elem(input logic [W-1:0] m, input int r, input int c);
        return m[(r*MS+c)*DW +: DW];
    endfunction

    function automatic logic [W-1:0] rand_mat(input bit full, input bit sm);
        logic [W-1:0] m;
        for (int q = 0; q < MS*MS; q++) begin
            if (full)    m[q*DW +: DW] = $urandom();
            else if (sm) m[q*DW +: DW] = 32'($urandom_range(0, 200)) - 32'd100;
            else         m[q*DW +: DW] = 32'($urandom_range(0, 255));
        end
        return m;
    endfunction

    function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int q = 0; q < MS*MS; q++) begin
            if (x[q*DW +: DW] !== y[q*DW +: DW]) return q;
        end
        return 0;
    endfunction

    function automatic void model(input int size, input bit sm, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input bit sat,
                                  output logic [W-1:0] c, output bit ovf);
        int n;
        logic signed [127:0] s, va, vb, hi, lo;
        logic [31:0] ea, eb, v;
        n   = (size > MS) ? MS : size;
        c   = '0;
        ovf = 1'b0;
        hi  = sm ? 128'sd2147483647 : 128'sd4294967295;
        lo  = sm ? -128'sd2147483648 : 128'sd0;
        for (int r = 0; r < n; r++) begin
            for (int col = 0; col < n; col++) begin
                s = '0;
                for (int k = 0; k < n; k++) begin
                    ea = elem(a, r, k);
                    eb = elem(b, k, col);
                    va = sm ? {{96{ea[31]}}, ea} : {96'd0, ea};
                    vb = sm ? {{96{eb[31]}}, eb} : {96'd0, eb};
                    s  = s + va * vb;
                end
                if (s > hi) begin
                    ovf = 1'b1;
                    v   = sat ? hi[31:0] : s[31:0];
                end else if (s < lo) begin
                    ovf = 1'b1;
                    v   = sat ? lo[31:0] : s[31:0];
                end else begin
                    v = s[31:0];
                end
                c = put(c, r, col, v);
            end
        end
    endfunction

    task automatic drive(input int size, input bit sm, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit v);
        bus_s.matrix_size = size;  bus_t.matrix_size = size;
        bus_s.signed_mode = sm;    bus_t.signed_mode = sm;
        bus_s.A = a;               bus_t.A = a;
        bus_s.B = b;               bus_t.B = b;
        bus_s.in_valid = v;        bus_t.in_valid = v;
    endtask

    task automatic set_ready(input bit r);
        bus_s.out_ready = r;
        bus_t.out_ready = r;
    endtask

    // Enters and leaves on a falling edge. hold > 0 stalls the consumer and
    // keeps in_valid up through the handshake edge.
    task automatic run_job(input int size, input bit sm, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int hold, output logic [W-1:0] c_obs);
        exp_t e;
        int   n, lat, idx;
        bit   seen;
        n = (size > MS) ? MS : size;
        model(size, sm, a, b, 1'b1, e.c_sat, e.ovf_sat);
        model(size, sm, a, b, 1'b0, e.c_trn, e.ovf_trn);
        e.lat = n*n + 2;
        sb.push_back(e);
        c_obs = '0;

        checks++;
        if (bus_s.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_idle got %b want 1", bus_s.in_ready);
        end
        drive(size, sm, a, b, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive($urandom_range(0, 12), ~sm, rand_mat(1'b1, 1'b0), rand_mat(1'b1, 1'b0), 1'b0);

        lat  = 0;
        seen = 1'b0;
        for (int m = 1; m <= 300; m++) begin
            if (bus_s.out_valid === 1'b1) begin
                lat  = m;
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        e = sb.pop_front();

        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL out_valid_timeout got none within 300 cycles want latency %0d", e.lat);
            return;
        end
        checks++;
        if (lat != e.lat) begin
            errors++;
            $display("FAIL latency got %0d want %0d", lat, e.lat);
        end
        checks++;
        if (bus_s.C !== e.c_sat) begin
            errors++;
            idx = first_diff(bus_s.C, e.c_sat);
            $display("FAIL c_sat elem %0d got %h want %h", idx, bus_s.C[idx*DW +: DW], e.c_sat[idx*DW +: DW]);
        end
        checks++;
        if (bus_s.overflow !== e.ovf_sat) begin
            errors++;
            $display("FAIL ovf_sat got %b want %b", bus_s.overflow, e.ovf_sat);
        end
        checks++;
        if (bus_t.out_valid !== 1'b1 || bus_t.C !== e.c_trn) begin
            errors++;
            idx = first_diff(bus_t.C, e.c_trn);
            $display("FAIL c_trn valid %b elem %0d got %h want %h", bus_t.out_valid, idx,
                     bus_t.C[idx*DW +: DW], e.c_trn[idx*DW +: DW]);
        end
        checks++;
        if (bus_t.overflow !== e.ovf_trn) begin
            errors++;
            $display("FAIL ovf_trn got %b want %b", bus_t.overflow, e.ovf_trn);
        end
        checks++;
        if (bus_s.in_ready !== 1'b0 || bus_s.busy !== 1'b1) begin
            errors++;
            $display("FAIL done_flags got in_ready %b busy %b want 0 1", bus_s.in_ready, bus_s.busy);
        end
        c_obs = bus_s.C;

        for (int h = 0; h < hold; h++) begin
            drive(2, 1'b0, rand_mat(1'b1, 1'b0), rand_mat(1'b1, 1'b0), 1'b1);
            @(negedge clk);
            checks++;
            if (bus_s.out_valid !== 1'b1 || bus_s.in_ready !== 1'b0 || bus_s.C !== e.c_sat
                || bus_s.overflow !== e.ovf_sat) begin
                errors++;
                $display("FAIL hold cycle %0d got valid %b ready %b want 1 0 with C stable",
                         h, bus_s.out_valid, bus_s.in_ready);
            end
        end

        set_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(1'b0);
        checks++;
        if (bus_s.out_valid !== 1'b0 || bus_s.in_ready !== 1'b1 || bus_s.busy !== 1'b0) begin
            errors++;
            $display("FAIL release got valid %b ready %b busy %b want 0 1 0",
                     bus_s.out_valid, bus_s.in_ready, bus_s.busy);
        end
        checks++;
        if (bus_s.C !== e.c_sat || bus_s.overflow !== e.ovf_sat) begin
            errors++;
            $display("FAIL idle_readback got ovf %b want %b (C differs: %b)", bus_s.overflow,
                     e.ovf_sat, bus_s.C !== e.c_sat);
        end
        bus_s.in_valid = 1'b0;
        bus_t.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_s.in_ready !== 1'b1 || bus_s.out_valid !== 1'b0 || bus_s.busy !== 1'b0
            || bus_s.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got ready %b valid %b busy %b ovf %b want 1 0 0 0",
                     bus_s.in_ready, bus_s.out_valid, bus_s.busy, bus_s.overflow);
        end
        checks++;
        if (bus_s.C !== '0 || bus_t.C !== '0) begin
            errors++;
            $display("FAIL reset_c got nonzero want 0");
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned_2x2();
        logic [W-1:0] a, b, c;
        a = '0; b = '0;
        a = put(a, 0, 0, 1); a = put(a, 0, 1, 2); a = put(a, 1, 0, 3); a = put(a, 1, 1, 4);
        b = put(b, 0, 0, 5); b = put(b, 0, 1, 6); b = put(b, 1, 0, 7); b = put(b, 1, 1, 8);
        run_job(2, 1'b0, a, b, 0, c);
        checks++;
        if (elem(c, 0, 0) !== 32'd19 || elem(c, 0, 1) !== 32'd22 || elem(c, 1, 0) !== 32'd43
            || elem(c, 1, 1) !== 32'd50) begin
            errors++;
            $display("FAIL u2x2_values got %0d %0d %0d %0d want 19 22 43 50",
                     elem(c, 0, 0), elem(c, 0, 1), elem(c, 1, 0), elem(c, 1, 1));
        end
    endtask

    task automatic test_signed_neg_identity();
        logic [W-1:0] a, b, c;
        a = '0; b = '0;
        for (int r = 0; r < 3; r++) begin
            a = put(a, r, r, 32'hFFFF_FFFF);
            for (int q = 0; q < 3; q++) b = put(b, r, q, 32'(r*3 + q + 1));
        end
        run_job(3, 1'b1, a, b, 0, c);
        checks++;
        if (elem(c, 2, 2) !== 32'hFFFF_FFF7 || elem(c, 0, 0) !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL neg_identity got %h %h want ffffffff fffffff7", elem(c, 0, 0), elem(c, 2, 2));
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] a, c;
        a = put('0, 0, 0, 32'h0001_0000);
        run_job(1, 1'b0, a, a, 0, c);
        checks++;
        if (elem(c, 0, 0) !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL unsigned_clamp got %h want ffffffff", elem(c, 0, 0));
        end
        a = put('0, 0, 0, 32'h8000_0000);
        run_job(1, 1'b1, a, a, 0, c);
        checks++;
        if (elem(c, 0, 0) !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL signed_clamp got %h want 7fffffff", elem(c, 0, 0));
        end
        a = put('0, 0, 0, 32'h8000_0000);
        a = put(a, 0, 1, 32'h7FFF_FFFF);
        run_job(2, 1'b1, a, rand_mat(1'b1, 1'b1), 0, c);
    endtask

    task automatic test_sizes();
        logic [W-1:0] a, c;
        run_job(0, 1'b0, rand_mat(1'b1, 1'b0), rand_mat(1'b1, 1'b0), 0, c);
        checks++;
        if (c !== '0) begin
            errors++;
            $display("FAIL size_zero got nonzero C want 0");
        end
        a = '0;
        for (int r = 0; r < MS; r++) a = put(a, r, r, 32'd1);
        run_job(15, 1'b0, a, a, 0, c);
        checks++;
        if (c !== a) begin
            errors++;
            $display("FAIL size_clamp elem %0d got %h want %h", first_diff(c, a),
                     elem(c, first_diff(c, a) / MS, first_diff(c, a) % MS),
                     elem(a, first_diff(c, a) / MS, first_diff(c, a) % MS));
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] c;
        run_job(2, 1'b0, rand_mat(1'b0, 1'b0), rand_mat(1'b0, 1'b0), 20, c);
    endtask

    task automatic test_reset_mid_job();
        logic [W-1:0] c;
        drive(4, 1'b0, rand_mat(1'b0, 1'b0), rand_mat(1'b0, 1'b0), 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(4, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_s.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_job_busy got %b want 1", bus_s.busy);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus_s.busy !== 1'b0 || bus_s.out_valid !== 1'b0 || bus_s.in_ready !== 1'b1
            || bus_s.C !== '0 || bus_t.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort got busy %b valid %b ready %b want 0 0 1 with C zero",
                     bus_s.busy, bus_s.out_valid, bus_s.in_ready);
        end
        run_job(2, 1'b1, rand_mat(1'b0, 1'b1), rand_mat(1'b0, 1'b1), 0, c);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] c;
        bit sm, full;
        for (int t = 0; t < 8; t++) begin
            sm   = 1'($urandom_range(0, 1));
            full = 1'($urandom_range(0, 1));
            run_job($urandom_range(0, 5), sm, rand_mat(full, sm), rand_mat(full, sm), 0, c);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, '0, '0, 1'b0);
        set_ready(1'b0);
        test_reset();
        test_unsigned_2x2();
        test_signed_neg_identity();
        test_overflow();
        test_sizes();
        test_backpressure();
        test_reset_mid_job();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
